// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline control unit.
//   state_t       : run/freeze/halt state encoding
//   rule_t        : which priority rule decides the current cycle's controls
//   DEFAULT_CNT_W : default width of the performance counters
package pipeline_pkg;

  localparam int DEFAULT_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FREEZE = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // Listed in priority order; the first one that matches wins.
  typedef enum logic [2:0] {
    RULE_HALTED = 3'd0,
    RULE_FREEZE = 3'd1,
    RULE_HALT   = 3'd2,
    RULE_BRANCH = 3'd3,
    RULE_STALL  = 3'd4,
    RULE_NORMAL = 3'd5
  } rule_t;

  // A cycle is "unfrozen" when the pipeline actually advanced state
  // decisions: neither memory-frozen nor parked in HALTED.
  function automatic logic is_unfrozen(rule_t r);
    return (r != RULE_FREEZE) && (r != RULE_HALTED);
  endfunction

endpackage

// File: rtl/pipeline_control_unit_if.sv
// Bundle of request inputs and control/status outputs of the pipeline
// control unit.
//   master : the core side (hazard unit, EX, MEM, WB) driving requests and
//            consuming the register enables, flushes and status.
//   slave  : the control unit itself.
// Requests : stall, branch_taken, mem_busy, halt, counter_clear
// Controls : pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
//            if_id_flush, id_ex_flush
// Status   : halted, hazard_error, load_stalls, branch_flushes, freeze_cycles
interface pipeline_control_unit_if
  import pipeline_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
);

  logic             stall;
  logic             branch_taken;
  logic             mem_busy;
  logic             halt;
  logic             counter_clear;

  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_write;
  logic             ex_mem_write;
  logic             mem_wb_write;
  logic             if_id_flush;
  logic             id_ex_flush;

  logic             halted;
  logic             hazard_error;
  logic [CNT_W-1:0] load_stalls;
  logic [CNT_W-1:0] branch_flushes;
  logic [CNT_W-1:0] freeze_cycles;

  modport master (
    output stall, branch_taken, mem_busy, halt, counter_clear,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
    input  if_id_flush, id_ex_flush,
    input  halted, hazard_error, load_stalls, branch_flushes, freeze_cycles
  );

  modport slave (
    input  stall, branch_taken, mem_busy, halt, counter_clear,
    output pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
    output if_id_flush, id_ex_flush,
    output halted, hazard_error, load_stalls, branch_flushes, freeze_cycles
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk, reset : clock and asynchronous active-high reset
//   inc        : count one event this cycle (ignored once at all-ones)
//   clr        : synchronous clear; beats inc in the same cycle
//   count      : current value
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (inc && (count_reg != {WIDTH{1'b1}})) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipeline_control_unit.sv
// Central pipeline control for the 5-stage core.
// Turns the load-use stall, branch flush, memory-busy and halt requests
// into the PC / pipeline-register write enables and bubble flushes, keeps a
// RUN/FREEZE/HALTED state machine, a sticky double-stall error flag and three
// saturating performance counters.
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : slave side of pipeline_control_unit_if (requests in,
//           controls and status out)
module pipeline_control_unit
  import pipeline_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  pipeline_control_unit_if.slave  bus
);

  state_t state_reg;
  state_t state_next;
  rule_t  rule;

  // Was the last unfrozen cycle a load-use stall?
  logic   stall_prev_reg;
  logic   stall_prev_next;
  logic   hazard_error_reg;
  logic   hazard_error_next;

  logic   pc_write;
  logic   if_id_write;
  logic   id_ex_write;
  logic   ex_mem_write;
  logic   mem_wb_write;
  logic   if_id_flush;
  logic   id_ex_flush;

  // Priority decode. FREEZE needs no rule of its own: once mem_busy drops
  // the held inputs are judged exactly as in RUN.
  always_comb begin
    rule = RULE_NORMAL;
    if (state_reg == ST_HALTED) begin
      rule = RULE_HALTED;
    end else if (bus.mem_busy) begin
      rule = RULE_FREEZE;
    end else if (bus.halt) begin
      rule = RULE_HALT;
    end else if (bus.branch_taken) begin
      rule = RULE_BRANCH;
    end else if (bus.stall) begin
      rule = RULE_STALL;
    end
  end

  // Control outputs and next state.
  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    id_ex_write  = 1'b0;
    ex_mem_write = 1'b0;
    mem_wb_write = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    state_next   = state_reg;

    case (rule)
      RULE_HALTED: begin
        state_next = ST_HALTED;
      end
      RULE_FREEZE: begin
        state_next = ST_FREEZE;
      end
      RULE_HALT: begin
        state_next = ST_HALTED;
      end
      RULE_BRANCH: begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        mem_wb_write = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        state_next   = ST_RUN;
      end
      RULE_STALL: begin
        // Hold PC and IF/ID, push a bubble into ID/EX, let the rest drain.
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        mem_wb_write = 1'b1;
        id_ex_flush  = 1'b1;
        state_next   = ST_RUN;
      end
      default: begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        mem_wb_write = 1'b1;
        state_next   = ST_RUN;
      end
    endcase
  end

  // Frozen cycles leave the stall history untouched, so a stall on either
  // side of a freeze still counts as back-to-back.
  always_comb begin
    stall_prev_next   = stall_prev_reg;
    hazard_error_next = hazard_error_reg;
    if (is_unfrozen(rule)) begin
      stall_prev_next = (rule == RULE_STALL);
    end
    if ((rule == RULE_STALL) && stall_prev_reg) begin
      hazard_error_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= ST_RUN;
      stall_prev_reg   <= 1'b0;
      hazard_error_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      stall_prev_reg   <= stall_prev_next;
      hazard_error_reg <= hazard_error_next;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_load_stalls (
    .clk   (clk),
    .reset (reset),
    .inc   (rule == RULE_STALL),
    .clr   (bus.counter_clear),
    .count (bus.load_stalls)
  );

  sat_counter #(.WIDTH(CNT_W)) u_branch_flushes (
    .clk   (clk),
    .reset (reset),
    .inc   (rule == RULE_BRANCH),
    .clr   (bus.counter_clear),
    .count (bus.branch_flushes)
  );

  sat_counter #(.WIDTH(CNT_W)) u_freeze_cycles (
    .clk   (clk),
    .reset (reset),
    .inc   (rule == RULE_FREEZE),
    .clr   (bus.counter_clear),
    .count (bus.freeze_cycles)
  );

  assign bus.pc_write     = pc_write;
  assign bus.if_id_write  = if_id_write;
  assign bus.id_ex_write  = id_ex_write;
  assign bus.ex_mem_write = ex_mem_write;
  assign bus.mem_wb_write = mem_wb_write;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_flush  = id_ex_flush;
  assign bus.halted       = (state_reg == ST_HALTED);
  assign bus.hazard_error = hazard_error_reg;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Scoreboard bench for pipeline_control_unit: the stimulus process computes
// the expected outputs of each cycle from a behavioural model and queues
// them; the monitor pops and compares on the falling edge.
module tb_pipeline_control_unit;

  localparam int W = 16;
  localparam int MAXC = (1 << W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  pipeline_control_unit_if #(.CNT_W(W)) bus ();

  pipeline_control_unit #(.CNT_W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [6:0]   ctl;   // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_fl, id_ex_fl}
    logic         halted;
    logic         err;
    logic [W-1:0] ls;
    logic [W-1:0] bf;
    logic [W-1:0] fc;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit m_halted;
  bit m_last_stall;
  bit m_err;
  int m_ls, m_bf, m_fc;
  bit verbose = 1'b1;

  task automatic model_reset();
    m_halted = 0; m_last_stall = 0; m_err = 0;
    m_ls = 0; m_bf = 0; m_fc = 0;
  endtask

  function automatic int sat_inc(int v);
    return (v < MAXC) ? v + 1 : v;
  endfunction

  // Drive one cycle's inputs, queue the expectation, advance the model to
  // the state it will hold after the next rising edge.
  task automatic apply(input bit st, input bit br, input bit mb,
                       input bit hl, input bit clr);
    exp_t e;
    bit is_freeze, is_stall, is_branch, unfrozen;
    bus.stall = st; bus.branch_taken = br; bus.mem_busy = mb;
    bus.halt = hl; bus.counter_clear = clr;

    is_freeze = 0; is_stall = 0; is_branch = 0; unfrozen = 0;
    if (m_halted) begin
      e.ctl = 7'b00000_00;
    end else if (mb) begin
      e.ctl = 7'b00000_00; is_freeze = 1;
    end else if (hl) begin
      e.ctl = 7'b00000_00; unfrozen = 1;
    end else if (br) begin
      e.ctl = 7'b11111_11; is_branch = 1; unfrozen = 1;
    end else if (st) begin
      e.ctl = 7'b00111_01; is_stall = 1; unfrozen = 1;
    end else begin
      e.ctl = 7'b11111_00; unfrozen = 1;
    end
    e.halted = m_halted;
    e.err = m_err;
    e.ls = W'(m_ls); e.bf = W'(m_bf); e.fc = W'(m_fc);
    sb.push_back(e);
    if (verbose)
      $display("t=%0t in st=%0b br=%0b mb=%0b hl=%0b clr=%0b -> exp ctl=%07b halted=%0b err=%0b ls=%0d bf=%0d fc=%0d",
               $time, st, br, mb, hl, clr, e.ctl, e.halted, e.err, m_ls, m_bf, m_fc);

    if (is_stall && m_last_stall) m_err = 1;
    if (unfrozen) m_last_stall = is_stall;
    if (!m_halted && !mb && hl) m_halted = 1;
    if (clr) begin
      m_ls = 0; m_bf = 0; m_fc = 0;
    end else begin
      if (is_stall)  m_ls = sat_inc(m_ls);
      if (is_branch) m_bf = sat_inc(m_bf);
      if (is_freeze) m_fc = sat_inc(m_fc);
    end
  endtask

  task automatic cyc(input bit st, input bit br, input bit mb,
                     input bit hl, input bit clr);
    @(posedge clk); #1;
    apply(st, br, mb, hl, clr);
  endtask

  // Asynchronous reset pulse between edges; the same cycle is then checked
  // with idle inputs, before any further edge.
  task automatic pulse_reset();
    @(posedge clk); #1;
    bus.stall = 0; bus.branch_taken = 0; bus.mem_busy = 0;
    bus.halt = 0; bus.counter_clear = 0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
    apply(0, 0, 0, 0, 0);
  endtask

  task automatic cmp(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        cmp("ctl", 32'({bus.pc_write, bus.if_id_write, bus.id_ex_write,
                        bus.ex_mem_write, bus.mem_wb_write,
                        bus.if_id_flush, bus.id_ex_flush}), 32'(e.ctl));
        cmp("halted", 32'(bus.halted), 32'(e.halted));
        cmp("hazard_error", 32'(bus.hazard_error), 32'(e.err));
        cmp("load_stalls", 32'(bus.load_stalls), 32'(e.ls));
        cmp("branch_flushes", 32'(bus.branch_flushes), 32'(e.bf));
        cmp("freeze_cycles", 32'(bus.freeze_cycles), 32'(e.fc));
      end
    end
  end

  // Stimulus
  initial begin
    bus.stall = 0; bus.branch_taken = 0; bus.mem_busy = 0;
    bus.halt = 0; bus.counter_clear = 0;
    model_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    apply(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Single stall, then idle
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Two back-to-back stalls set the sticky error
    pulse_reset();
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Branch held through a 3-cycle memory freeze
    pulse_reset();
    repeat (3) cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Halt, then branches are ignored; reset releases
    pulse_reset();
    cyc(0, 0, 0, 1, 0);
    repeat (3) cyc(0, 1, 0, 0, 0);
    pulse_reset();
    cyc(0, 0, 0, 0, 0);

    // Halt waits for mem_busy to drop
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);

    // Freeze between two stalls does not break the sequence
    pulse_reset();
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Clear beats an increment in the same cycle
    cyc(0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);

    // Randomised traffic
    verbose = 1'b0;
    pulse_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        pulse_reset();
      end else begin
        cyc($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 15,
            $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 1,
            $urandom_range(0, 99) < 4);
      end
    end

    // Saturation of load_stalls, then clear
    pulse_reset();
    for (int i = 0; i < MAXC + 3; i++) cyc(1, 0, 0, 0, 0);
    verbose = 1'b1;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_control_unit.md
# pipeline_control_unit

Central pipeline control: consumes the load-use `stall` request, the branch-taken flush request, the data-memory busy signal and the halt retirement, and drives the write-enable and flush controls of the PC and all four pipeline registers. It sits beside the hazard detection and forwarding logic in the 5-stage core. It holds a small run/freeze/halt state machine, a sticky protocol-error flag and saturating performance counters.

## Interface
- `CNT_W`, 16: width of each performance counter.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `stall`  in  1  load-use stall request from hazard detection.
- `branch_taken`  in  1  branch resolved taken in EX.
- `mem_busy`  in  1  data memory not ready; the whole pipeline must hold.
- `halt`  in  1  HALT instruction retiring in WB.
- `counter_clear`  in  1  synchronous clear of all counters.
- `pc_write`, `if_id_write`, `id_ex_write`, `ex_mem_write`, `mem_wb_write`  out  1 each  register load enables.
- `if_id_flush`, `id_ex_flush`  out  1 each  load a NOP bubble instead of the data.
- `halted`  out  1  core is in HALTED.
- `hazard_error`  out  1  sticky: `stall` held for more than one unfrozen cycle.
- `load_stalls`, `branch_flushes`, `freeze_cycles`  out  CNT_W each  saturating counters.

## Operation
- States: RUN, FREEZE, HALTED.
- Control outputs are combinational from the state and the current inputs. The first matching rule applies:
  1. HALTED: all writes 0, all flushes 0.
  2. `mem_busy`=1: all writes 0, flushes 0. Next state is FREEZE.
  3. `halt`=1: all writes 0, flushes 0. Next state is HALTED.
  4. `branch_taken`=1: all writes 1, `if_id_flush`=1, `id_ex_flush`=1. Branch overrides `stall`.
  5. `stall`=1: `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1; `id_ex_write`, `ex_mem_write` and `mem_wb_write` are 1.
  6. Otherwise: all writes 1, flushes 0.
- State transitions:
  - FREEZE returns to RUN on the first cycle with `mem_busy`=0. That cycle applies rules 3–6 against the held inputs.
  - HALTED is left only by reset.
- Counters saturate at all-ones and never wrap.
  - `load_stalls` increments on each cycle where rule 5 applies.
  - `branch_flushes` increments on each cycle where rule 4 applies.
  - `freeze_cycles` increments on each cycle where rule 2 applies.
- `counter_clear` zeroes all counters on the next edge and overrides an increment in the same cycle. It has no effect on state or `hazard_error`.
- `hazard_error` is set when rule 5 applied in the previous unfrozen cycle and applies again now. Freeze cycles in between neither break nor extend the sequence. Only reset clears it.

## Timing
- Control outputs have zero latency, with no registered delay. State, counters and the error flag update on the rising edge of `clk`.
- Load-use stall is exactly one bubble cycle. Hazard detection drops `stall` once the bubble occupies ID/EX.
- Reset values: state RUN, `halted`=0, `hazard_error`=0, all counters 0. While in RUN, the controls follow the rules above.
- Reset asserted mid-freeze or while HALTED returns to RUN immediately, asynchronously.
- `mem_busy` and `branch_taken` asserted together: freeze for the duration of `mem_busy`. The flush is applied on the first cycle after `mem_busy` drops, because EX holds the branch. It is counted once.
- `halt` together with `mem_busy`: the halt takes effect on the first non-busy cycle.

## Structure
- Shared package `pipeline_pkg`: the state encoding (RUN=2'd0, FREEZE=2'd1, HALTED=2'd2) and the default `CNT_W`.
- One sub-module `sat_counter` (parameter width; inputs `inc`, `clr`; asynchronous reset), instantiated three times.
- The FSM, the priority decode and the error flag live in the top module.

## Test plan
- Reset asserted, then released with all inputs 0 → all writes 1, flushes 0, counters 0, `halted`=0.
- `stall` for 1 cycle → `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1 that cycle; `load_stalls`=1; `hazard_error` stays 0.
- `stall` for 2 consecutive cycles → `hazard_error`=1 from the second edge, and it stays 1 after `stall` drops.
- `mem_busy` for 3 cycles with `branch_taken`=1 throughout → 3 cycles with all writes 0; then one cycle with both flushes set; `freeze_cycles`=3, `branch_flushes`=1.
- `halt`=1 → `halted`=1 on the next edge and all writes 0 thereafter, even with `branch_taken`=1. Asynchronous reset pulse → back to RUN.
- Drive `stall` for 0xFFFF+3 separated cycles with CNT_W=16 → `load_stalls` holds at 0xFFFF. `counter_clear` → 0 on the next edge.
